// File: rtl/bus_fifo_pkg.sv
// Shared constants and helpers for the bus-side transmit FIFO bank.
package bus_fifo_pkg;

    localparam int ID_W      = 8;
    localparam int OVF_W     = 8;
    localparam int MAX_DEPTH = 64;

    // Occupancy must reach DEPTH itself, hence the +1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef logic [$clog2(MAX_DEPTH + 1)-1:0] cnt_max_t;

    // Destination id sits in the top ID_W bits of a packet.
    function automatic logic [ID_W-1:0] pkt_id(input logic [63:0] pkt, input int pckg_sz);
        return ID_W'(pkt >> (pckg_sz - ID_W));
    endfunction

endpackage

// File: rtl/bus_fifo_ch.sv
// One show-ahead transmit FIFO channel: memory, pointers, occupancy and overflow counter.
// Overflow policy is selected by the DROP_OLDEST_EN macro (default: drop the incoming entry).
module bus_fifo_ch
    import bus_fifo_pkg::*;
#(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [PCKG_SZ-1:0]         din,
    output logic                       full,
    input  logic                       pop,
    output logic [PCKG_SZ-1:0]         dout,
    output logic                       pndng,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [OVF_W-1:0]           ovf_cnt
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [PCKG_SZ-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    cnt_t               count_q;
    logic [OVF_W-1:0]   ovf_q;

    logic do_pop;
    logic ovf;
    logic do_write;
    logic drop_head;
    logic cnt_inc;
    logic cnt_dec;

    // Handshake: push and pop are sampled on the rising edge; pop is honoured only
    // while pndng is high, and dout always shows the head entry (show-ahead).
    always_comb begin
        do_pop = pop && (count_q != '0);
        full   = (count_q == DEPTH_C);
        ovf    = push && full && !do_pop;
`ifdef DROP_OLDEST_EN
        do_write  = push;
        drop_head = ovf;
`else
        do_write  = push && !ovf;
        drop_head = 1'b0;
`endif
        cnt_inc = do_write && !drop_head && !do_pop;
        cnt_dec = do_pop && !do_write;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            // A dropped head advances the read side exactly like a pop.
            if (do_pop || drop_head) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (cnt_inc) begin
                count_q <= count_q + cnt_t'(1);
            end else if (cnt_dec) begin
                count_q <= count_q - cnt_t'(1);
            end
            if (ovf && (ovf_q != '1)) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    assign dout    = mem[rd_ptr];
    assign pndng   = (count_q != '0);
    assign count   = count_q;
    assign ovf_cnt = ovf_q;

endmodule

// File: rtl/bus_fifo_bank.sv
// Per-terminal transmit FIFO bank: DRVRS independent bus_fifo_ch channels with flattened ports.
// Build option: define DROP_OLDEST_EN to discard the head instead of the incoming entry on overflow.
module bus_fifo_bank
    import bus_fifo_pkg::*;
#(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8,
    parameter int BITS    = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [DRVRS-1:0]                       dev_push,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]          dev_data,
    output logic [DRVRS-1:0]                       full,
    input  logic [DRVRS-1:0]                       pop,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]          D_pop,
    output logic [DRVRS-1:0]                       pndng,
    output logic [DRVRS-1:0][$clog2(DEPTH+1)-1:0]  count,
    output logic [DRVRS-1:0][OVF_W-1:0]            ovf_cnt
);

    // Only bus 0 is served; BITS is carried for interface compatibility.
    if ((BITS < 1) || (DRVRS < 1) || (DRVRS > 16) || (DEPTH < 2) || (DEPTH > MAX_DEPTH) ||
        ((DEPTH & (DEPTH - 1)) != 0) || (PCKG_SZ <= ID_W)) begin : g_bad_cfg
        $error("bus_fifo_bank: unsupported parameter combination");
    end

    for (genvar i = 0; i < DRVRS; i++) begin : g_ch
        bus_fifo_ch #(
            .PCKG_SZ (PCKG_SZ),
            .DEPTH   (DEPTH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .push    (dev_push[i]),
            .din     (dev_data[i]),
            .full    (full[i]),
            .pop     (pop[i]),
            .dout    (D_pop[i]),
            .pndng   (pndng[i]),
            .count   (count[i]),
            .ovf_cnt (ovf_cnt[i])
        );
    end

endmodule
